// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle control FSM for an ARM-style datapath.
// Sequences fetch/decode/execute/memory/writeback, holds NZCV and traps memory timeouts.
module multicycle_controller #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instruction,
    input  logic [3:0]  i_alu_flags,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_ir_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_adr_src,
    output logic        o_reg_write,
    output logic        o_pc_src,
    output logic        o_alu_src_b,
    output logic        o_result_src,
    output logic [3:0]  o_alu_control,
    output logic [3:0]  o_flags,
    output logic        o_undef_instr,
    output logic        o_bus_error
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_ADR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_ERROR
    } state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_flags;
    logic [CW-1:0] r_wait, w_wait_inc;
    logic          r_undef, w_undef;
    logic          w_cond_ok, w_cmd_ok, w_is_cmp, w_flag_we, w_mem_state, w_timeout;
    logic [3:0]    w_alu_op;
    logic          w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
    logic [3:0]    w_cond, w_cmd;
    logic [1:0]    w_op;
    logic          w_i, w_s, w_n, w_z, w_c, w_v, w_unused;

    assign w_cond   = i_instruction[31:28];
    assign w_op     = i_instruction[27:26];
    assign w_i      = i_instruction[25];
    assign w_cmd    = i_instruction[24:21];
    assign w_s      = i_instruction[20];
    assign w_unused = ^i_instruction[19:0];
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            4'h0: w_cond_ok = w_z;
            4'h1: w_cond_ok = !w_z;
            4'h2: w_cond_ok = w_c;
            4'h3: w_cond_ok = !w_c;
            4'h4: w_cond_ok = w_n;
            4'h5: w_cond_ok = !w_n;
            4'h6: w_cond_ok = w_v;
            4'h7: w_cond_ok = !w_v;
            4'h8: w_cond_ok = w_c && !w_z;
            4'h9: w_cond_ok = !w_c || w_z;
            4'hA: w_cond_ok = w_n == w_v;
            4'hB: w_cond_ok = w_n != w_v;
            4'hC: w_cond_ok = !w_z && (w_n == w_v);
            4'hD: w_cond_ok = w_z || (w_n != w_v);
            4'hE: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // CMP shares the SUB ALU code but never writes back
    always_comb begin
        w_cmd_ok = 1'b1;
        w_alu_op = 4'b0000;
        case (w_cmd)
            4'b0100:          w_alu_op = 4'b0000;
            4'b0010, 4'b1010: w_alu_op = 4'b0001;
            4'b0000:          w_alu_op = 4'b0010;
            4'b1100:          w_alu_op = 4'b0011;
            4'b0001:          w_alu_op = 4'b0100;
            4'b1101:          w_alu_op = 4'b0101;
            default:          w_cmd_ok = 1'b0;
        endcase
    end

    assign w_is_cmp    = w_cmd == 4'b1010;
    assign w_mem_state = r_state == S_FETCH || r_state == S_MEM_RD || r_state == S_MEM_WR;
    assign w_wait_inc  = r_wait + CW'(1);
    assign w_timeout   = w_mem_state && !i_mem_ready && w_wait_inc == CW'(WAIT_LIMIT);

    always_comb begin
        w_next        = r_state;
        w_undef       = 1'b0;
        w_flag_we     = 1'b0;
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        o_adr_src     = 1'b0;
        o_pc_src      = 1'b0;
        o_alu_src_b   = 1'b0;
        o_result_src  = 1'b0;
        o_alu_control = 4'b0000;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_ir_write = i_mem_ready;
                w_pc_write = i_mem_ready;
                w_next     = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_next  = !w_cond_ok    ? S_FETCH :
                          w_op == 2'b00 ? S_EXEC :
                          w_op == 2'b01 ? S_MEM_ADR :
                          w_op == 2'b10 ? S_BRANCH : S_FETCH;
                w_undef = w_cond_ok && w_op == 2'b11;
            end
            S_EXEC: begin
                o_alu_src_b   = w_i;
                o_alu_control = w_alu_op;
                w_flag_we     = w_cmd_ok && (w_s || w_is_cmp);
                w_undef       = !w_cmd_ok;
                w_next        = (!w_cmd_ok || w_is_cmp) ? S_FETCH : S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_ADR: begin
                o_alu_src_b = 1'b1;
                w_next      = w_s ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                o_adr_src  = 1'b1;
                w_next     = i_mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                o_result_src = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                o_adr_src   = 1'b1;
                w_next      = i_mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                w_pc_write = 1'b1;
                o_pc_src   = 1'b1;
                w_next     = S_FETCH;
            end
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_ERROR;
    end

    // enables are masked by reset so an aborted instruction cannot write back
    assign o_pc_write    = w_pc_write && i_rst_n;
    assign o_ir_write    = w_ir_write && i_rst_n;
    assign o_mem_read    = w_mem_read && i_rst_n;
    assign o_mem_write   = w_mem_write && i_rst_n;
    assign o_reg_write   = w_reg_write && i_rst_n;
    assign o_flags       = r_flags;
    assign o_undef_instr = r_undef;
    assign o_bus_error   = r_state == S_ERROR;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
            r_wait  <= '0;
            r_undef <= 1'b0;
        end else begin
            r_state <= w_next;
            r_undef <= w_undef;
            r_wait  <= (w_mem_state && !i_mem_ready && !w_timeout) ? w_wait_inc : '0;
            if (w_flag_we) r_flags <= i_alu_flags;
        end
    end
endmodule
